// File: rtl/wb_stream_port.sv
// Wishbone B4 classic slave exposing a byte-stream port: DATA writes feed an AXIS master,
// AXIS slave bytes are popped by DATA reads. Each direction is buffered by a 2**DEPTH_LOG2 FIFO.
module wb_stream_port #(
    parameter int DEPTH_LOG2    = 4,
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [WB_ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic                     wb_we_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o,
    input  logic [7:0]               s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);

    localparam int             DEPTH      = 1 << DEPTH_LOG2;
    localparam int             CW         = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);
    localparam logic [1:0]     REG_DATA   = 2'd0;
    localparam logic [1:0]     REG_STATUS = 2'd1;
    localparam logic [1:0]     REG_CTRL   = 2'd2;

    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0]         tx_count;
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0]         rx_count;
    logic                  tx_enable, tx_err;

    logic tx_full, tx_empty, rx_full, rx_empty;
    logic req, data_wr, tx_push, tx_overflow, tx_pop, tx_flush;
    logic rx_pop, rx_push, rx_flush, ctrl_wr, status_clr, err_cycle;
    logic [1:0] reg_sel;
    logic [WB_DATA_WIDTH-1:0] rd_data;
    logic unused_bits;

    assign tx_full  = (tx_count == FULL_COUNT);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == FULL_COUNT);
    assign rx_empty = (rx_count == '0);

    // A request is only accepted while no response is on the bus, so a held
    // strobe produces one ack/err every other cycle.
    assign req     = wb_stb_i & wb_cyc_i & ~(wb_ack_o | wb_err_o);
    assign reg_sel = wb_adr_i[3:2];

    assign data_wr     = req & wb_we_i & (reg_sel == REG_DATA) & wb_sel_i[0];
    assign tx_push     = data_wr & ~tx_full;
    assign tx_overflow = data_wr & tx_full;
    assign ctrl_wr     = req & wb_we_i & (reg_sel == REG_CTRL);
    assign tx_flush    = ctrl_wr & wb_dat_i[1];
    assign rx_flush    = ctrl_wr & wb_dat_i[2];
    assign status_clr  = req & wb_we_i & (reg_sel == REG_STATUS) & wb_dat_i[4];
    assign rx_pop      = req & ~wb_we_i & (reg_sel == REG_DATA) & ~rx_empty;
    assign err_cycle   = tx_overflow | (req & (reg_sel == 2'd3));

    // AXIS: a byte moves when tvalid & tready are both high at a rising edge; the
    // source holds tdata stable while tvalid is high and tready is low.
    assign tx_pop        = (~m_axis_tvalid | m_axis_tready) & tx_enable & ~tx_empty & ~tx_flush;
    assign s_axis_tready = ~rx_full;
    assign rx_push       = s_axis_tvalid & s_axis_tready;
    assign wb_rty_o      = 1'b0;

    assign unused_bits = ^{wb_adr_i[WB_ADDR_WIDTH-1:4], wb_adr_i[1:0],
                           wb_dat_i[WB_DATA_WIDTH-1:8], wb_sel_i[3:1]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!rx_empty) begin
                    rd_data[WB_DATA_WIDTH-1] = 1'b1;
                    rd_data[7:0]             = rx_mem[rx_rd_ptr];
                end
            end
            REG_STATUS: begin
                rd_data[0]       = tx_full;
                rd_data[1]       = tx_empty;
                rd_data[2]       = rx_full;
                rd_data[3]       = rx_empty;
                rd_data[4]       = tx_err;
                rd_data[8 +: CW]  = tx_count;
                rd_data[16 +: CW] = rx_count;
            end
            REG_CTRL: rd_data[0] = tx_enable;
            default:  rd_data = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
            tx_enable <= 1'b1;
            tx_err    <= 1'b0;
        end else begin
            wb_ack_o <= req & ~err_cycle;
            wb_err_o <= err_cycle;
            wb_dat_o <= (req & ~wb_we_i & ~err_cycle) ? rd_data : '0;
            if (ctrl_wr)
                tx_enable <= wb_dat_i[0];
            if (tx_overflow)
                tx_err <= 1'b1;
            else if (status_clr)
                tx_err <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (tx_push & ~tx_flush)
            tx_mem[tx_wr_ptr] <= wb_dat_i[7:0];
        if (rx_push & ~rx_flush)
            rx_mem[rx_wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else if (tx_flush) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    // The output register keeps its byte across flushes and tx_enable=0; only a
    // handshake with nothing to reload drops tvalid.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (tx_pop) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= tx_mem[tx_rd_ptr];
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else if (rx_flush) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_port.sv
// Directed and randomized bench for wb_stream_port against a queue-based reference model
// that is stepped at every rising edge and compared with all outputs at every falling edge.
module tb_wb_stream_port;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o, wb_rty_o;
    logic [3:0]  wb_sel_i;
    logic [7:0]  s_axis_tdata, m_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;

    int checks   = 0;
    int failures = 0;
    bit rand_axis = 1'b0;

    // Reference model: exp_q is the TX FIFO, rx_q the RX FIFO, m_ov/m_od the TX output register.
    logic [7:0]  exp_q[$];
    logic [7:0]  rx_q[$];
    logic        m_ov, m_txen, m_txerr, m_ack, m_err;
    logic [7:0]  m_od;
    logic [31:0] m_dat;

    logic        last_ack, last_err;
    logic [31:0] last_dat;
    int          n_ack, n_err;

    always #5 i_clk = ~i_clk;

    wb_stream_port #(.DEPTH_LOG2(4), .WB_DATA_WIDTH(32), .WB_ADDR_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
    );

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        rx_q.delete();
        m_ov = 1'b0; m_od = 8'h00; m_txen = 1'b1; m_txerr = 1'b0;
        m_ack = 1'b0; m_err = 1'b0; m_dat = 32'h0;
    endtask

    // One clock of the block's rules, using the state as it was before the edge.
    task automatic model_step();
        int txn, rxn;
        bit req, nack, nerr, tx_push, tx_flush, rx_pop, rx_flush, rx_push, load, new_en;
        logic [31:0] ndat;
        if (!i_rst_n) begin
            model_reset();
            return;
        end
        txn = exp_q.size();
        rxn = rx_q.size();
        req = wb_stb_i && wb_cyc_i && !(m_ack || m_err);
        nack = 0; nerr = 0; ndat = 32'h0;
        tx_push = 0; tx_flush = 0; rx_pop = 0; rx_flush = 0;
        new_en = m_txen;
        if (req) begin
            case (wb_adr_i[3:2])
                2'd0: begin
                    if (wb_we_i) begin
                        if (wb_sel_i[0] && txn == 16) begin
                            nerr = 1;
                            m_txerr = 1'b1;
                        end else begin
                            nack = 1;
                            tx_push = wb_sel_i[0];
                        end
                    end else begin
                        nack = 1;
                        if (rxn > 0) begin
                            ndat = 32'h8000_0000 | 32'(rx_q[0]);
                            rx_pop = 1;
                        end
                    end
                end
                2'd1: begin
                    nack = 1;
                    if (wb_we_i) begin
                        if (wb_dat_i[4]) m_txerr = 1'b0;
                    end else begin
                        ndat = (32'(rxn) << 16) | (32'(txn) << 8) | (32'(m_txerr) << 4)
                             | ((rxn == 0) ? 32'h8 : 32'h0) | ((rxn == 16) ? 32'h4 : 32'h0)
                             | ((txn == 0) ? 32'h2 : 32'h0) | ((txn == 16) ? 32'h1 : 32'h0);
                    end
                end
                2'd2: begin
                    nack = 1;
                    if (wb_we_i) begin
                        new_en   = wb_dat_i[0];
                        tx_flush = wb_dat_i[1];
                        rx_flush = wb_dat_i[2];
                    end else begin
                        ndat = 32'(m_txen);
                    end
                end
                default: nerr = 1;
            endcase
        end
        rx_push = s_axis_tvalid && (rxn < 16);
        load    = (!m_ov || m_axis_tready) && m_txen && (txn > 0) && !tx_flush;
        if (load) begin
            m_od = exp_q.pop_front();
            m_ov = 1'b1;
        end else if (m_axis_tready) begin
            m_ov = 1'b0;
        end
        if (tx_flush) exp_q.delete();
        else if (tx_push) exp_q.push_back(wb_dat_i[7:0]);
        if (rx_pop) void'(rx_q.pop_front());
        if (rx_flush) rx_q.delete();
        else if (rx_push) rx_q.push_back(s_axis_tdata);
        m_txen = new_en;
        m_ack = nack; m_err = nerr; m_dat = ndat;
    endtask

    task automatic compare_all();
        check("ack", wb_ack_o, m_ack);
        check("err", wb_err_o, m_err);
        if (m_ack) check("rd_data", wb_dat_o, m_dat);
        check("m_tvalid", m_axis_tvalid, m_ov);
        if (m_ov) check("m_tdata", m_axis_tdata, m_od);
        check("s_tready", s_axis_tready, rx_q.size() < 16);
        check("rty", wb_rty_o, 1'b0);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
        compare_all();
        if (rand_axis) begin
            s_axis_tvalid = ($urandom_range(0, 1) == 1);
            s_axis_tdata  = 8'($urandom);
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        tick();
        last_ack = wb_ack_o;
        last_err = wb_err_o;
        last_dat = wb_dat_o;
    endtask

    task automatic wb_finish();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tick();
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        wb_start(we, adr, dat, sel);
        wb_finish();
    endtask

    initial begin
        logic [31:0] d;
        int op;
        i_rst_n = 1'b0;
        wb_adr_i = 0; wb_dat_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_stb_i = 0; wb_cyc_i = 0;
        s_axis_tvalid = 0; s_axis_tdata = 0; m_axis_tready = 1;
        model_reset();
        repeat (3) tick();
        check("rst_dat_o", wb_dat_o, 32'h0);
        check("rst_m_tdata", m_axis_tdata, 32'h0);
        i_rst_n = 1'b1;

        wb_xfer(0, 32'h4, 0, 4'hF);
        check("status_after_reset", last_dat, 32'h0000_000A);
        wb_xfer(0, 32'h8, 0, 4'hF);
        check("ctrl_after_reset", last_dat, 32'h1);

        // TX stream: queue three bytes while disabled, then release them back to back.
        wb_xfer(1, 32'h8, 32'h0, 4'hF);
        wb_xfer(1, 32'h0, 32'h41, 4'h1);
        wb_xfer(1, 32'h0, 32'h42, 4'h1);
        wb_xfer(1, 32'h0, 32'h43, 4'h1);
        wb_xfer(1, 32'h8, 32'h1, 4'hF);
        check("tx_stream_b0", {m_axis_tvalid, m_axis_tdata}, 9'h141);
        tick();
        check("tx_stream_b1", {m_axis_tvalid, m_axis_tdata}, 9'h142);
        tick();
        check("tx_stream_b2", {m_axis_tvalid, m_axis_tdata}, 9'h143);
        tick();
        check("tx_stream_done", m_axis_tvalid, 1'b0);
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("tx_stream_status", last_dat, 32'h0000_000A);

        // TX full: one byte parks in the output register, sixteen fill the FIFO, the next errs.
        m_axis_tready = 1'b0;
        n_ack = 0; n_err = 0;
        for (int i = 0; i < 18; i++) begin
            wb_xfer(1, 32'h0, (i == 0) ? 32'h55 : 32'(8'h60 + i), 4'h1);
            n_ack += int'(last_ack);
            n_err += int'(last_err);
        end
        check("tx_full_acks", n_ack, 17);
        check("tx_full_errs", n_err, 1);
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("tx_full_status", last_dat, 32'h0000_1019);
        wb_xfer(1, 32'h0, 32'h99, 4'hE);
        check("sel0_low_ack_when_full", {last_ack, last_err}, 2'b10);
        wb_xfer(1, 32'h4, 32'h10, 4'hF);
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("tx_err_cleared", last_dat, 32'h0000_1009);

        // Backpressure: the parked byte stays put across waiting, flush and disable.
        repeat (10) begin
            tick();
            check("hold_tdata", {m_axis_tvalid, m_axis_tdata}, 9'h155);
        end
        wb_xfer(1, 32'h8, 32'h3, 4'hF);
        check("flush_keeps_out", {m_axis_tvalid, m_axis_tdata}, 9'h155);
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("flush_status", last_dat, 32'h0000_000A);
        wb_xfer(1, 32'h8, 32'h0, 4'hF);
        check("disable_keeps_out", {m_axis_tvalid, m_axis_tdata}, 9'h155);
        wb_xfer(1, 32'h8, 32'h1, 4'hF);
        m_axis_tready = 1'b1;
        tick();
        check("out_drained", m_axis_tvalid, 1'b0);

        // RX fill to full, then drain in order.
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = 8'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        check("rx_full_tready", s_axis_tready, 1'b0);
        for (int i = 0; i < 16; i++) begin
            wb_start(0, 32'h0, 0, 4'hF);
            check("rx_pop_data", last_dat, 32'h8000_0000 | 32'(i));
            if (i == 0) check("rx_tready_back", s_axis_tready, 1'b1);
            wb_finish();
        end
        wb_xfer(0, 32'h0, 0, 4'hF);
        check("rx_empty_read", {last_ack, last_err, last_dat}, {2'b10, 32'h0});

        // Simultaneous RX pop/push.
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = 8'h80 + 8'(i);
            s_axis_tvalid = 1'b1;
            tick();
        end
        s_axis_tdata = 8'hA0;
        wb_xfer(0, 32'h0, 0, 4'hF);
        check("rx_pop_at_full", last_dat, 32'h8000_0080);
        s_axis_tvalid = 1'b0;
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("rx_refilled", last_dat, 32'h0010_0006);
        wb_xfer(0, 32'h0, 0, 4'hF);
        check("rx_pop_81", last_dat, 32'h8000_0081);
        s_axis_tdata = 8'hA1;
        s_axis_tvalid = 1'b1;
        wb_start(0, 32'h0, 0, 4'hF);
        s_axis_tvalid = 1'b0;
        check("rx_pop_push_same", last_dat, 32'h8000_0082);
        wb_finish();
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("rx_count_kept", last_dat, 32'h000F_0002);
        for (int i = 3; i < 18; i++) begin
            wb_xfer(0, 32'h0, 0, 4'hF);
            check("rx_order", last_dat,
                  32'h8000_0000 | ((i < 16) ? 32'(8'h80 + i) : 32'(8'hA0 + (i - 16))));
        end

        // Decode: reg 3 errs with no effect; address bits outside [3:2] are ignored.
        wb_xfer(1, 32'hC, 32'hFFFF_FFFF, 4'hF);
        check("bad_write_err", {last_ack, last_err}, 2'b01);
        wb_xfer(0, 32'h1234_560C, 0, 4'hF);
        check("bad_read_err", {last_ack, last_err}, 2'b01);
        wb_xfer(0, 32'h0000_0104, 0, 4'hF);
        check("alias_status", last_dat, 32'h0000_000A);

        // Held strobe: a response every other cycle.
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h8;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("held_stb_ack", wb_ack_o, (i % 2 == 0));
        end
        wb_finish();

        // Reset in the middle of traffic.
        m_axis_tready = 1'b0;
        wb_xfer(1, 32'h0, 32'h99, 4'h1);
        wb_xfer(1, 32'h0, 32'h9A, 4'h1);
        s_axis_tdata = 8'h33; s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        wb_start(0, 32'h4, 0, 4'hF);
        check("pre_reset_ack", wb_ack_o, 1'b1);
        #1 i_rst_n = 1'b0;
        #1;
        check("async_rst_ack", wb_ack_o, 1'b0);
        check("async_rst_err", wb_err_o, 1'b0);
        check("async_rst_tvalid", m_axis_tvalid, 1'b0);
        check("async_rst_s_tready", s_axis_tready, 1'b1);
        model_reset();
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        m_axis_tready = 1'b1;
        wb_xfer(0, 32'h4, 0, 4'hF);
        check("status_after_midreset", last_dat, 32'h0000_000A);
        wb_xfer(0, 32'h8, 0, 4'hF);
        check("ctrl_after_midreset", last_dat, 32'h1);

        // Randomized traffic checked against the model every cycle.
        rand_axis = 1'b1;
        for (int n = 0; n < 700; n++) begin
            op = $urandom_range(0, 9);
            d  = $urandom;
            if (op <= 3) begin
                wb_xfer(1, ($urandom & 32'hFFFF_FFF3), d,
                        ($urandom_range(0, 4) == 0) ? 4'hE : 4'hF);
            end else if (op <= 5) begin
                wb_xfer(0, ($urandom & 32'hFFFF_FFF3), 0, 4'hF);
            end else if (op == 6) begin
                wb_xfer($urandom_range(0, 1) == 1, ($urandom & 32'hFFFF_FFF3) | 32'h4, d, 4'hF);
            end else if (op == 7) begin
                d[0] = ($urandom_range(0, 7) != 0);
                d[1] = ($urandom_range(0, 7) == 0);
                d[2] = ($urandom_range(0, 7) == 0);
                wb_xfer($urandom_range(0, 2) != 0, 32'h8, d, 4'hF);
            end else if (op == 8) begin
                wb_xfer($urandom_range(0, 1) == 1, 32'hC, d, 4'hF);
            end else begin
                wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = 32'h4;
                repeat ($urandom_range(1, 4)) tick();
                wb_finish();
            end
        end
        rand_axis = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        wb_xfer(1, 32'h8, 32'h1, 4'hF);
        repeat (20) tick();
        check("final_tx_drained", m_axis_tvalid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
